// File: rtl/serial_full_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Counter width is derived from the operand width.
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit counter width; WIDTH is at least 2 so $clog2 is never 0.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_full_adder_if.sv
// Request/result bundle for the bit-serial adder.
// ovf exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_full_adder_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif

endinterface

// File: rtl/serial_full_adder_fa.sv
// One-bit full adder built from two half adders
// and an OR for the carry.
module half_adder (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;

endmodule

module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .x_i (a_i),
    .y_i (b_i),
    .s_o (s0),
    .c_o (c0)
  );

  half_adder u_ha1 (
    .x_i (s0),
    .y_i (c_i),
    .s_o (s_o),
    .c_o (c1)
  );

  assign c_o = c0 | c1;

endmodule

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow flag.
module serial_full_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic          clk,
  input logic          rst,
  serial_full_adder_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             done_q;
  logic             busy_q;
  logic             fa_s;
  logic             fa_c;
  logic             last;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  full_adder_cell u_fa (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  assign res_d = {fa_s, res_q[WIDTH-1:1]};
  assign last  = (cnt_q == CW'(WIDTH - 1));

  // Sequencer plus datapath: capture, shift, complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sr_q  <= bus.a;
            b_sr_q  <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sr_q  <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
          res_q   <= res_d;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            sum_q   <= res_d;
            cout_q  <= fa_c;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef SERIAL_ADD_OVF_EN
            // carry_q here is the carry into the MSB.
            ovf_q   <= carry_q ^ fa_c;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_full_adder.md
Name: serial_full_adder

Overview:
- Bit-serial N-bit adder: the inverse arithmetic direction of the team's subtractor blocks.
- Accepts two WIDTH-bit operands plus a carry-in on a start pulse.
- Resolves one bit per clock, LSB first, through a single hierarchical full-adder cell with a registered carry.
- Reports sum and carry-out with a one-cycle done pulse. Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand/sum width in bits (legal range 2..32).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result becomes valid.
- sum  output  WIDTH  result, registered; updated only at completion.
- cout  output  1  final carry-out, registered; updated only at completion.
- ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Shift registers, carry register and bit counter all cleared.
- States: IDLE, RUN.
- IDLE:
  - start=1 → capture a, b into shift registers; carry_reg=cin; count=0; go to RUN.
  - busy=1 from the next cycle.
- RUN, each edge:
  - Full-adder cell computes s = a_sr[0]^b_sr[0]^carry_reg and c = majority(a_sr[0], b_sr[0], carry_reg).
  - s shifts into the MSB of the result shift register; a_sr and b_sr shift right; carry_reg=c; count++.
  - At count==WIDTH-1 (the WIDTH-th RUN edge): sum ← completed result; cout ← c; done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: start accepted at edge T0 → done high after edge T_WIDTH. For WIDTH=8, done rises 8 cycles after the start edge.
- start while busy: ignored, no queuing. Operands and cin may change freely during RUN.
- start asserted in the cycle done is high: accepted (state is IDLE); back-to-back throughput is one result per WIDTH+1 cycles.
- sum/cout hold their last completed value until the next completion, not cleared on new start.
- rst mid-RUN: operation aborted, no done pulse, outputs return to reset values.
- Arithmetic is unsigned modulo 2^WIDTH; {cout,sum} equals a+b+cin exactly.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Port ovf exists.
  - At completion, ovf ← carry into MSB XOR carry out of MSB, i.e. two's-complement overflow.
  - Registered alongside sum; reset to 0.
- Undefined: no ovf port, no extra register; all other behaviour identical.

Decomposition:
- Package serial_add_pkg:
  - state enum {IDLE, RUN}.
  - Counter width constant: $clog2(WIDTH).
  - Default WIDTH constant.
- Sub-module full_adder_cell: combinational; two half adders plus OR for carry, mirroring the team's half/full hierarchy. Instantiated once.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0, start one cycle → done after 8 cycles with sum=0x8D, cout=0; busy high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; with the macro, ovf=0.
- a=0x00, b=0x00, cin=1 → sum=0x01, cout=0; with the macro: a=0x7F, b=0x01, cin=0 → sum=0x80, ovf=1.
- Start accepted, then start pulsed again on cycle 3 with different operands → ignored; result matches the first operands; only one done pulse.
- rst asserted on cycle 4 of RUN → busy=0, done never pulses, sum=0, cout=0. A new start afterwards completes correctly.
- start held high continuously with a=0x10, b=0x20 → a done pulse every 9 cycles, sum=0x30 each time; random sweep of 1000 operand/cin triples against a reference model.
